// File: rtl/us_tx_arbiter.sv
// Upstream UDP transmit arbiter: three packet sources share one UDP tx port.
// Optional REQ-state abort on TIMEOUT is enabled by defining US_TX_ARB_TIMEOUT_EN.
module us_tx_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  src_req,
    input  logic [10:0] src_len0,
    input  logic [10:0] src_len1,
    input  logic [10:0] src_len2,
    input  logic [1:0]  src_code0,
    input  logic [1:0]  src_code1,
    input  logic [1:0]  src_code2,
    input  logic [7:0]  src_data0,
    input  logic [7:0]  src_data1,
    input  logic [7:0]  src_data2,
    output logic [2:0]  src_grant,
    output logic [2:0]  src_enable,
    output logic [1:0]  udp_tx_request,
    output logic [10:0] udp_tx_length,
    output logic [7:0]  udp_tx_data,
    input  logic        udp_tx_enable,
    input  logic [6:0]  bs_ratio,
    input  logic        stall_req,
    output logic        stall_ack,
    output logic        timeout_err
);

    if (GAP < 1 || GAP > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("us_tx_arbiter: GAP must be 1..15 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_t;

    state_t      state_q, state_n;
    logic [2:0]  grant_n;
    logic [1:0]  code_n;
    logic [10:0] len_n;
    logic [10:0] byte_cnt, cnt_n;
    logic [3:0]  gap_cnt, gap_n;
    logic [6:0]  bs_credit, credit_n;
    logic [2:0]  valid, win;
    logic [10:0] sel_len;
    logic [1:0]  sel_code;

`ifdef US_TX_ARB_TIMEOUT_EN
    logic [15:0] to_cnt, to_n;
    logic        terr_n;
`endif

    // ch0 always first; ch1/ch2 contention settled by bandscope credit
    always_comb begin
        valid = src_req & {|src_len2, |src_len1, |src_len0};
        win   = 3'b000;
        if (valid[0])
            win = 3'b001;
        else if (valid[1] && valid[2])
            win = (bs_credit >= bs_ratio) ? 3'b100 : 3'b010;
        else if (valid[1])
            win = 3'b010;
        else if (valid[2])
            win = 3'b100;
    end

    always_comb begin
        sel_len  = '0;
        sel_code = '0;
        unique case (1'b1)
            win[0]: begin sel_len = src_len0; sel_code = src_code0; end
            win[1]: begin sel_len = src_len1; sel_code = src_code1; end
            win[2]: begin sel_len = src_len2; sel_code = src_code2; end
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        grant_n   = src_grant;
        code_n    = udp_tx_request;
        len_n     = udp_tx_length;
        cnt_n     = byte_cnt;
        gap_n     = gap_cnt;
        credit_n  = bs_credit;
        stall_ack = 1'b0;
`ifdef US_TX_ARB_TIMEOUT_EN
        to_n      = '0;
        terr_n    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (stall_req) begin
                    stall_ack = 1'b1;
                end else if (win != 3'b000) begin
                    grant_n = win;
                    code_n  = sel_code;
                    len_n   = sel_len;
                    state_n = S_REQ;
                    if (win[2])
                        credit_n = '0;
                end
            end
            S_REQ: begin
                if (udp_tx_enable) begin
                    cnt_n   = udp_tx_length - 11'd1;
                    state_n = S_XFER;
`ifdef US_TX_ARB_TIMEOUT_EN
                end else if (to_cnt == 16'(TIMEOUT - 1)) begin
                    terr_n  = 1'b1;
                    grant_n = '0;
                    code_n  = '0;
                    gap_n   = 4'(GAP - 1);
                    state_n = S_GAP;
                end else begin
                    to_n = to_cnt + 16'd1;
`endif
                end
            end
            S_XFER: begin
                if (byte_cnt == '0) begin
                    grant_n = '0;
                    code_n  = '0;
                    gap_n   = 4'(GAP - 1);
                    state_n = S_GAP;
                    if (src_grant[1] && bs_credit != 7'd127)
                        credit_n = bs_credit + 7'd1;
                end else begin
                    cnt_n = byte_cnt - 11'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0)
                    state_n = S_IDLE;
                else
                    gap_n = gap_cnt - 4'd1;
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
                code_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            src_grant      <= '0;
            udp_tx_request <= '0;
            udp_tx_length  <= '0;
            byte_cnt       <= '0;
            gap_cnt        <= '0;
            bs_credit      <= '0;
        end else begin
            state_q        <= state_n;
            src_grant      <= grant_n;
            udp_tx_request <= code_n;
            udp_tx_length  <= len_n;
            byte_cnt       <= cnt_n;
            gap_cnt        <= gap_n;
            bs_credit      <= credit_n;
        end
    end

`ifdef US_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_n;
            timeout_err <= terr_n;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign src_enable = src_grant & {3{udp_tx_enable}};

    always_comb begin
        udp_tx_data = '0;
        unique case (1'b1)
            src_grant[0]: udp_tx_data = src_data0;
            src_grant[1]: udp_tx_data = src_data1;
            src_grant[2]: udp_tx_data = src_data2;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_us_tx_arbiter.sv
// Bench for us_tx_arbiter: packet-level reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_us_tx_arbiter;
    localparam int TO = 16;
    localparam int GP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_req;
    logic [10:0] l0, l1, l2;
    logic [1:0]  c0, c1, c2;
    logic [7:0]  d0, d1, d2;
    logic        en, stall_req;
    logic [6:0]  bs_ratio;
    logic [2:0]  src_grant, src_enable;
    logic [1:0]  udp_tx_request;
    logic [10:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        stall_ack, timeout_err;

    us_tx_arbiter #(.TIMEOUT(TO), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .src_req(src_req),
        .src_len0(l0), .src_len1(l1), .src_len2(l2),
        .src_code0(c0), .src_code1(c1), .src_code2(c2),
        .src_data0(d0), .src_data1(d1), .src_data2(d2),
        .src_grant(src_grant), .src_enable(src_enable),
        .udp_tx_request(udp_tx_request), .udp_tx_length(udp_tx_length),
        .udp_tx_data(udp_tx_data), .udp_tx_enable(en),
        .bs_ratio(bs_ratio), .stall_req(stall_req),
        .stall_ack(stall_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] get_len(input int i);
        return (i == 0) ? l0 : (i == 1) ? l1 : l2;
    endfunction
    function automatic logic [1:0] get_code(input int i);
        return (i == 0) ? c0 : (i == 1) ? c1 : c2;
    endfunction
    function automatic logic [7:0] get_data(input int i);
        return (i == 0) ? d0 : (i == 1) ? d1 : d2;
    endfunction

    // phase: 0 idle, 1 waiting for accept, 2 sending, 3 inter-packet gap
    int ph = 0, owner = -1, mcode = 0, mlen = 0, credit = 0;
    int left = 0, gleft = 0, wcyc = 0, w;
    bit mterr = 1'b0;
    bit v1, v2;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; owner = -1; mcode = 0; mlen = 0;
            credit = 0; mterr = 1'b0;
        end else begin
            mterr = 1'b0;
            case (ph)
                0: if (!stall_req) begin
                    w  = -1;
                    v1 = src_req[1] && l1 != 0;
                    v2 = src_req[2] && l2 != 0;
                    if (src_req[0] && l0 != 0) w = 0;
                    else if (v1 && v2) w = (credit >= int'(bs_ratio)) ? 2 : 1;
                    else if (v1) w = 1;
                    else if (v2) w = 2;
                    if (w >= 0) begin
                        owner = w;
                        mcode = int'(get_code(w));
                        mlen  = int'(get_len(w));
                        ph    = 1;
                        wcyc  = 0;
                        if (w == 2) credit = 0;
                    end
                end
                1: if (en) begin
                    ph   = 2;
                    left = mlen;
                end else begin
                    wcyc++;
`ifdef US_TX_ARB_TIMEOUT_EN
                    if (wcyc == TO) begin
                        mterr = 1'b1; owner = -1; mcode = 0;
                        ph = 3; gleft = GP;
                    end
`endif
                end
                2: begin
                    left--;
                    if (left == 0) begin
                        if (owner == 1 && credit < 127) credit++;
                        owner = -1; mcode = 0;
                        ph = 3; gleft = GP;
                    end
                end
                default: begin
                    gleft--;
                    if (gleft == 0) ph = 0;
                end
            endcase
        end
    end

    logic [2:0] eg;
    always @(negedge clk) begin
        if (chk_en) begin
            eg = (owner < 0) ? 3'b000 : 3'(1 << owner);
            check("grant", src_grant, eg);
            check("src_enable", src_enable, eg & {3{en}});
            check("request", udp_tx_request, mcode);
            check("length", udp_tx_length, mlen);
            check("data", udp_tx_data, (owner < 0) ? 8'h00 : get_data(owner));
            check("stall_ack", stall_ack, (ph == 0) && stall_req);
            check("timeout_err", timeout_err, mterr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [2:0] g, input int lim, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (src_grant == g) begin ok = 1'b1; break; end
        end
        check(nm, ok, 1);
    endtask

    int n, g, k;
    bit saw;
    int ord[8];
    int exp_ord[8] = '{1, 1, 1, 2, 1, 1, 1, 2};

    initial begin
        rst = 1'b1; src_req = '0; en = 1'b0; stall_req = 1'b0; bs_ratio = '0;
        l0 = '0; l1 = '0; l2 = '0; c0 = '0; c1 = '0; c2 = '0;
        d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_grant", src_grant, 0);
        check("rst_length", udp_tx_length, 0);
        tick();
        rst = 1'b0;

        // zero-length request is never granted
        l0 = 11'd0; c0 = 2'b01; src_req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("len0_nogrant", src_grant, 0);
        end

        // ch0 60-byte packet, accept 3 cycles after request
        tick();
        l0 = 11'd60;
        @(negedge clk);
        @(negedge clk);
        check("t1_latency", src_grant, 3'b001);
        check("t1_code", udp_tx_request, 2'b01);
        tick(); tick();
        en = 1'b1; src_req = 3'b000; stall_req = 1'b1;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (src_grant != 3'b001) break;
            n++;
        end
        check("t1_xfer_cycles", n, 60);
        g = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall_ack) break;
            g++;
            @(negedge clk);
        end
        check("t1_gap_cycles", g, 2);
        tick();
        stall_req = 1'b0;

        // stall raised mid ch1 packet with ch0 pending
        l1 = 11'd20; c1 = 2'b10; l0 = 11'd5; c0 = 2'b11; src_req = 3'b010;
        wait_grant(3'b010, 10, "t3_ch1_grant");
        repeat (5) tick();
        stall_req = 1'b1; src_req = 3'b011;
        wait_grant(3'b000, 40, "t3_ch1_done");
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall_ack) begin saw = 1'b1; break; end
        end
        check("t3_stall_ack", saw, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_held", src_grant, 0);
        end
        tick();
        stall_req = 1'b0;
        @(negedge clk);
        check("t3_idle", src_grant, 0);
        @(negedge clk);
        check("t3_ch0", src_grant, 3'b001);
        tick();
        src_req = 3'b000;
        wait_grant(3'b000, 20, "t3_ch0_done");
        repeat (4) tick();

        // REQ with no accept
        en = 1'b0; l0 = 11'd8; src_req = 3'b001;
        wait_grant(3'b001, 5, "t4_grant");
        tick();
        src_req = 3'b000;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw |= timeout_err;
        end
`ifdef US_TX_ARB_TIMEOUT_EN
        check("t4_terr_seen", saw, 1);
        check("t4_grant_cleared", src_grant, 0);
`else
        check("t4_terr_quiet", saw, 0);
        check("t4_grant_held", src_grant, 3'b001);
`endif
        tick();
        en = 1'b1;
        repeat (20) tick();

        // ch1/ch2 contention with bs_ratio=3 from clean credit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bs_ratio = 7'd3; l1 = 11'd1032; l2 = 11'd1032; c1 = 2'b10; c2 = 2'b11;
        src_req = 3'b110;
        for (int p = 0; p < 8; p++) begin
            ord[p] = 0;
            for (int i = 0; i < 1200; i++) begin
                @(negedge clk);
                if (src_grant != 3'b000) break;
            end
            ord[p] = (src_grant == 3'b010) ? 1 : (src_grant == 3'b100) ? 2 : 0;
            check($sformatf("t5_order%0d", p), ord[p], exp_ord[p]);
            for (int i = 0; i < 1100; i++) begin
                @(negedge clk);
                if (src_grant == 3'b000) break;
            end
        end
        tick();
        src_req = 3'b000;
        repeat (3) tick();

        // reset in the middle of a long ch2 packet
        l2 = 11'd1032; src_req = 3'b100;
        wait_grant(3'b100, 10, "t6_ch2_grant");
        tick();
        repeat (500) tick();
        rst = 1'b1; src_req = 3'b000;
        tick();
        @(negedge clk);
        check("t6_grant", src_grant, 0);
        check("t6_enable", src_enable, 0);
        check("t6_request", udp_tx_request, 0);
        check("t6_length", udp_tx_length, 0);
        check("t6_data", udp_tx_data, 0);
        tick();
        rst = 1'b0; bs_ratio = 7'd1; l1 = 11'd7; src_req = 3'b110;
        @(negedge clk);
        @(negedge clk);
        check("t6_ch1_after_rst", src_grant, 3'b010);
        tick();
        src_req = 3'b000;
        repeat (20) tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom % 8 == 0) src_req = 3'($urandom);
            if ($urandom % 4 == 0) begin
                l0 = ($urandom % 6 == 0) ? 11'd0 : 11'($urandom_range(1, 24));
                l1 = ($urandom % 6 == 0) ? 11'd0 : 11'($urandom_range(1, 24));
                l2 = ($urandom % 6 == 0) ? 11'd0 : 11'($urandom_range(1, 24));
                c0 = 2'($urandom); c1 = 2'($urandom); c2 = 2'($urandom);
            end
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            en = ($urandom % 3 != 0);
            stall_req = ($urandom % 12 == 0);
            rst = ($urandom % 400 == 0);
            if ($urandom % 200 == 0) bs_ratio = 7'($urandom_range(0, 4));
        end
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/us_tx_arbiter.md
US_TX_ARBITER -- requirements
Module: us_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4096: cycles allowed in REQ before abort.
REQ-002 Parameter GAP, default 2: idle cycles between packets, legal range 1..15.
REQ-003 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 src_req  in  3  packet request per source: [0] discovery/response, [1] IQ (ep6), [2] bandscope (ep4).
REQ-007 src_len0/1/2  in  11 each  packet length in bytes; sampled at grant.
REQ-008 src_code0/1/2  in  2 each  UDP port code; sampled at grant.
REQ-009 src_data0/1/2  in  8 each  byte stream from each source.
REQ-010 src_grant  out  3  one-hot; high from grant until end of packet.
REQ-011 src_enable  out  3  one-hot copy of udp_tx_enable, routed to the granted source.
REQ-012 udp_tx_request  out  2  registered port code of the granted source; 0 when idle.
REQ-013 udp_tx_length  out  11  registered length of the granted packet.
REQ-014 udp_tx_data  out  8  src_dataN of the granted source; 0 when no grant.
REQ-015 udp_tx_enable  in  1  downstream accept; its first high cycle starts XFER.
REQ-016 bs_ratio  in  7  IQ packets required before bandscope wins a contention.
REQ-017 stall_req / stall_ack  in / out  1 each  quiesce handshake.
REQ-018 timeout_err  out  1  one-cycle pulse on a REQ abort.

Function
REQ-019 State machine states: IDLE, REQ, XFER, GAP. Unknown encodings go to IDLE.
REQ-020 IDLE, stall_req high: stall_ack=1 combinationally; no grant issued.
REQ-021 IDLE, otherwise: grant the winning requester with src_lenN!=0, latch its code and length, then go to REQ the next cycle. Grant latency is 1 cycle.
REQ-022 Requests with src_len==0 are never granted.
REQ-023 Priority order: stall_req > ch0 > {ch1, ch2}.
REQ-024 ch1 vs ch2 contention: ch2 wins iff bs_credit >= bs_ratio. bs_ratio=0 therefore gives ch2 priority.
REQ-025 bs_credit is 7 bits, reset 0. It increments (saturating at 127) on each completed ch1 packet and clears to 0 on each ch2 grant.
REQ-026 REQ: drive udp_tx_request and udp_tx_length. On udp_tx_enable, load byte_cnt=len-1 and go to XFER.
REQ-027 XFER: byte_cnt decrements every cycle. When byte_cnt==0 (len cycles in XFER total), drop the grant, zero udp_tx_request, and go to GAP.
REQ-028 A src_req deassertion during REQ or XFER is ignored; the packet runs to its counted length.
REQ-029 GAP: wait GAP cycles, then go to IDLE. No grant may issue during GAP.
REQ-030 stall_req asserted mid-packet: the packet completes, then GAP, then IDLE asserts stall_ack.
REQ-031 stall_req and ch0 request in the same IDLE cycle: the stall wins and ch0 is held.
REQ-032 len=1: a single XFER cycle, then GAP.

Reset
REQ-033 While rst is high, and on the cycle it releases, outputs take these values: state=IDLE, src_grant=0, src_enable=0, udp_tx_request=0, udp_tx_length=0, timeout_err=0, bs_credit=0, byte_cnt=0.
REQ-034 rst asserted mid-XFER aborts the packet immediately, with no completion or credit update.

Configuration
REQ-035 Macro US_TX_ARB_TIMEOUT_EN.
  Defined: a 16-bit counter runs in REQ. On reaching TIMEOUT without udp_tx_enable, the block pulses timeout_err, drops the grant, leaves bs_credit unchanged, and goes to GAP.
  Undefined: REQ waits indefinitely; timeout_err is tied to 0; no counter is present.

Verification
REQ-036 ch0 only, len=60, code=2'b01, enable 3 cycles after request -> grant 1 cycle after src_req; exactly 60 XFER cycles; then GAP=2 cycles; back to IDLE.
REQ-037 ch1 and ch2 held continuously, len=1032, bs_ratio=3 -> grant order 1,1,1,2,1,1,1,2,…
REQ-038 stall_req raised mid-ch1 XFER, ch0 pending -> ch1 completes; stall_ack high in IDLE; ch0 granted 1 cycle after stall_req drops.
REQ-039 With US_TX_ARB_TIMEOUT_EN, TIMEOUT=16, enable never asserted -> timeout_err pulse after 16 REQ cycles; grant cleared; IDLE after GAP. Without the macro -> grant held and timeout_err stays 0.
REQ-040 rst pulsed at XFER byte 500 of a 1032-byte ch2 packet -> all outputs 0 the next cycle; a fresh ch1 request is granted normally; bs_credit=0.
